// File: rtl/bind_handshake_monitor.sv
// bind_handshake_monitor
//
// Purpose:
//   Passive protocol checker for N_CH valid/ready channels, meant to be bound
//   into the parent of the block being observed. It only reads the channel
//   signals. For each channel it tracks the handshake and flags three kinds
//   of violation:
//     DROP    - valid deasserted while a transfer was still stalled
//     DATA    - payload changed while stalled (checked on the accepting cycle too)
//     TIMEOUT - a stall lasted longer than MAX_STALL cycles (once per episode)
//   It also keeps saturating per-channel transfer counters and a first-error
//   record that simulation or emulation can read back.
//
// Parameters:
//   N_CH        number of monitored channels (>= 1)
//   DATA_WIDTH  payload width per channel
//   MAX_STALL   stall cycles tolerated before TIMEOUT; 0 disables the check
//   COUNT_WIDTH width of each transfer counter
//
// Ports:
//   CLK          clock, all state on the rising edge
//   ASYNCRESET   asynchronous active-high reset
//   en           monitor enable; low = no checking, no counting, tracking cleared
//   clr          synchronous clear of counters, sticky flags and first-error record
//   valid        per-channel valid, bit i = channel i
//   ready        per-channel ready
//   data         payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_pulse    one-cycle pulse per channel, the cycle after a violation
//   err_sticky   per-channel sticky error flag
//   first_valid  first-error record holds an entry
//   first_chan   channel of the first error
//   first_code   1 = DROP, 2 = DATA, 3 = TIMEOUT, 0 = none
//   xfer_count   per-channel accepted-transfer counts, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]

module bind_handshake_monitor #(
  parameter int N_CH        = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_STALL   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                      CLK,
  input  logic                                      ASYNCRESET,
  input  logic                                      en,
  input  logic                                      clr,
  input  logic [N_CH-1:0]                           valid,
  input  logic [N_CH-1:0]                           ready,
  input  logic [N_CH*DATA_WIDTH-1:0]                data,
  output logic [N_CH-1:0]                           err_pulse,
  output logic [N_CH-1:0]                           err_sticky,
  output logic                                      first_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_chan,
  output logic [1:0]                                first_code,
  output logic [N_CH*COUNT_WIDTH-1:0]               xfer_count
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SCW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [SCW-1:0] STALL_LIMIT = SCW'(MAX_STALL);
  localparam bit TIMEOUT_ON = (MAX_STALL > 0);

  typedef enum logic [1:0] {
    CODE_NONE    = 2'd0,
    CODE_DROP    = 2'd1,
    CODE_DATA    = 2'd2,
    CODE_TIMEOUT = 2'd3
  } code_e;

  logic [N_CH-1:0]        xfer;
  logic [N_CH-1:0]        stall;
  logic [DATA_WIDTH-1:0]  data_ch     [N_CH];

  logic [N_CH-1:0]        pend_q;
  logic [DATA_WIDTH-1:0]  held_q      [N_CH];
  logic [SCW-1:0]         stall_cnt_q [N_CH];
  logic [N_CH-1:0]        fired_q;
  logic [COUNT_WIDTH-1:0] count_q     [N_CH];

  code_e                  code        [N_CH];
  logic [N_CH-1:0]        viol;
  logic [N_CH-1:0]        timeout_hit;

  logic                   first_hit;
  logic [CHW-1:0]         pick_chan;
  code_e                  pick_code;

  assign xfer  = valid & ready;
  assign stall = valid & ~ready;

  // Unpack the flat payload bus and pack the counters back onto the output bus.
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign data_ch[g] = data[g*DATA_WIDTH +: DATA_WIDTH];
    assign xfer_count[g*COUNT_WIDTH +: COUNT_WIDTH] = count_q[g];
  end

  // Per-channel violation detection. Only one code is reported per channel per
  // cycle, with DROP taking precedence over DATA, and DATA over TIMEOUT.
  // timeout_hit marks the episode as fired even if a higher-priority code masks
  // it, so a long stall can never produce a second TIMEOUT.
  always_comb begin
    viol        = '0;
    timeout_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      code[i]        = CODE_NONE;
      timeout_hit[i] = TIMEOUT_ON && en && stall[i] &&
                       (stall_cnt_q[i] == STALL_LIMIT) && !fired_q[i];
      if (en) begin
        if (pend_q[i] && !valid[i]) begin
          code[i] = CODE_DROP;
        end else if (pend_q[i] && (data_ch[i] != held_q[i])) begin
          code[i] = CODE_DATA;
        end else if (timeout_hit[i]) begin
          code[i] = CODE_TIMEOUT;
        end
      end
      viol[i] = (code[i] != CODE_NONE);
    end
  end

  // Pick the lowest-index channel that reports a violation this cycle. Scanning
  // from the top down lets the lowest index overwrite the others.
  always_comb begin
    first_hit = 1'b0;
    pick_chan = '0;
    pick_code = CODE_NONE;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (viol[i]) begin
        first_hit = 1'b1;
        pick_chan = CHW'(i);
        pick_code = code[i];
      end
    end
  end

  // Handshake tracking: remembers whether the channel was stalled last cycle,
  // the payload it was stalled with, and how long the current stall has lasted.
  // Any cycle that is not an enabled stall ends the episode, which also means
  // disabling the monitor can never leave a stale stall behind. clr does not
  // touch this state, so checking carries on seamlessly across a clear.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      pend_q  <= '0;
      fired_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        held_q[i]      <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (en && stall[i]) begin
          pend_q[i] <= 1'b1;
          held_q[i] <= data_ch[i];
          if (stall_cnt_q[i] != STALL_LIMIT) begin
            stall_cnt_q[i] <= stall_cnt_q[i] + SCW'(1);
          end
          if (timeout_hit[i]) begin
            fired_q[i] <= 1'b1;
          end
        end else begin
          pend_q[i]      <= 1'b0;
          held_q[i]      <= '0;
          stall_cnt_q[i] <= '0;
          fired_q[i]     <= 1'b0;
        end
      end
    end
  end

  // Reporting state: error pulses, sticky flags, first-error record and the
  // transfer counters. clr wins over everything detected in the same cycle,
  // so a violation coinciding with clr is dropped entirely.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      err_pulse   <= '0;
      err_sticky  <= '0;
      first_valid <= 1'b0;
      first_chan  <= '0;
      first_code  <= CODE_NONE;
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= '0;
      end
    end else if (clr) begin
      err_pulse   <= '0;
      err_sticky  <= '0;
      first_valid <= 1'b0;
      first_chan  <= '0;
      first_code  <= CODE_NONE;
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      err_pulse  <= viol;
      err_sticky <= err_sticky | viol;
      if (!first_valid && first_hit) begin
        first_valid <= 1'b1;
        first_chan  <= pick_chan;
        first_code  <= pick_code;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (en && xfer[i] && (count_q[i] != {COUNT_WIDTH{1'b1}})) begin
          count_q[i] <= count_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bind_handshake_monitor.sv
// tb_bind_handshake_monitor
//
// Purpose:
//   Self-checking bench for bind_handshake_monitor with two 8-bit channels,
//   MAX_STALL = 4 and 4-bit counters. A table of single-cycle vectors covers
//   the basic handshake, DROP, simultaneous DROP/DATA, enable and clear
//   behaviour; hand-written sequences cover timeout, counter saturation and
//   asynchronous reset in the middle of a stall.

module tb_bind_handshake_monitor;

  localparam int N_CH        = 2;
  localparam int DATA_WIDTH  = 8;
  localparam int MAX_STALL   = 4;
  localparam int COUNT_WIDTH = 4;

  logic        CLK;
  logic        ASYNCRESET;
  logic        en;
  logic        clr;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [15:0] data;
  logic [1:0]  err_pulse;
  logic [1:0]  err_sticky;
  logic        first_valid;
  logic [0:0]  first_chan;
  logic [1:0]  first_code;
  logic [7:0]  xfer_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        en;
    logic        clr;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [15:0] data;
    logic [1:0]  e_pulse;
    logic [1:0]  e_sticky;
    logic        e_fv;
    logic        e_fc;
    logic [1:0]  e_code;
    logic [7:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  bind_handshake_monitor #(
    .N_CH        (N_CH),
    .DATA_WIDTH  (DATA_WIDTH),
    .MAX_STALL   (MAX_STALL),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESET  (ASYNCRESET),
    .en          (en),
    .clr         (clr),
    .valid       (valid),
    .ready       (ready),
    .data        (data),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .first_valid (first_valid),
    .first_chan  (first_chan),
    .first_code  (first_code),
    .xfer_count  (xfer_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Append one vector: inputs for a cycle and the outputs expected right after
  // the following rising edge.
  task automatic addVec(input logic v_en, input logic v_clr,
                        input logic [1:0] v_valid, input logic [1:0] v_ready,
                        input logic [15:0] v_data,
                        input logic [1:0] v_pulse, input logic [1:0] v_sticky,
                        input logic v_fv, input logic v_fc, input logic [1:0] v_code,
                        input logic [7:0] v_count);
    vec_t v;
    v.en       = v_en;
    v.clr      = v_clr;
    v.valid    = v_valid;
    v.ready    = v_ready;
    v.data     = v_data;
    v.e_pulse  = v_pulse;
    v.e_sticky = v_sticky;
    v.e_fv     = v_fv;
    v.e_fc     = v_fc;
    v.e_code   = v_code;
    v.e_count  = v_count;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then move to 1 ns after the rising edge so the
  // registered outputs for that cycle can be sampled.
  task automatic applyStimulus(input logic s_en, input logic s_clr,
                               input logic [1:0] s_valid, input logic [1:0] s_ready,
                               input logic [15:0] s_data);
    en    = s_en;
    clr   = s_clr;
    valid = s_valid;
    ready = s_ready;
    data  = s_data;
    @(posedge CLK);
    #1;
  endtask

  // Compare all outputs against the expected values as one comparison.
  task automatic checkOutput(input string name,
                             input logic [1:0] e_pulse, input logic [1:0] e_sticky,
                             input logic e_fv, input logic e_fc, input logic [1:0] e_code,
                             input logic [7:0] e_count);
    logic [15:0] act;
    logic [15:0] exp;
    act = {err_pulse, err_sticky, first_valid, first_chan, first_code, xfer_count};
    exp = {e_pulse, e_sticky, e_fv, e_fc, e_code, e_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got pulse=%b sticky=%b first=%b/%0d/%0d count=%h, want pulse=%b sticky=%b first=%b/%0d/%0d count=%h",
               name, err_pulse, err_sticky, first_valid, first_chan, first_code, xfer_count,
               e_pulse, e_sticky, e_fv, e_fc, e_code, e_count);
    end
  endtask

  initial begin
    logic [3:0] c0;

    ASYNCRESET = 1'b1;
    en         = 1'b0;
    clr        = 1'b0;
    valid      = 2'b00;
    ready      = 2'b00;
    data       = 16'h0000;

    // en clr valid ready data       pulse sticky fv fc code count
    // Stall ch0 three cycles with steady payload, then accept.
    addVec(1, 0, 2'b01, 2'b00, 16'h005A, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b01, 2'b00, 16'h005A, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b01, 2'b00, 16'h005A, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b01, 2'b01, 16'h005A, 2'b00, 2'b00, 0, 0, 2'd0, 8'h01);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 2'd0, 8'h01);
    // Stall ch0 two cycles, then drop valid: DROP on ch0.
    addVec(1, 0, 2'b01, 2'b00, 16'h0033, 2'b00, 2'b00, 0, 0, 2'd0, 8'h01);
    addVec(1, 0, 2'b01, 2'b00, 16'h0033, 2'b00, 2'b00, 0, 0, 2'd0, 8'h01);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b01, 1, 0, 2'd1, 8'h01);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b01, 1, 0, 2'd1, 8'h01);
    // Clear, then ch1 DATA and ch0 DROP in the same cycle; ch0 wins the record.
    addVec(1, 1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b11, 2'b00, 16'h1144, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b10, 2'b00, 16'h2244, 2'b11, 2'b11, 1, 0, 2'd1, 8'h00);
    // ch1 now drops too; the first-error record must not change.
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b11, 1, 0, 2'd1, 8'h00);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h00);
    // Stall, then drop valid while disabled: no error across the enable edge.
    addVec(1, 0, 2'b01, 2'b00, 16'h0077, 2'b00, 2'b11, 1, 0, 2'd1, 8'h00);
    addVec(0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h00);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h00);
    // Transfers are not counted while disabled, counted when enabled.
    addVec(0, 0, 2'b11, 2'b11, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h00);
    addVec(1, 0, 2'b11, 2'b11, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h11);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b11, 1, 0, 2'd1, 8'h11);
    // A DROP coinciding with clr is discarded.
    addVec(1, 0, 2'b01, 2'b00, 16'h0010, 2'b00, 2'b11, 1, 0, 2'd1, 8'h11);
    addVec(1, 1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);
    addVec(1, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 2'd0, 8'h00);

    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_state", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);
    ASYNCRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].valid, vecs[i].ready, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_pulse, vecs[i].e_sticky,
                  vecs[i].e_fv, vecs[i].e_fc, vecs[i].e_code, vecs[i].e_count);
    end

    // ch1 stalls 10 cycles: the 5th stall cycle sees 4 prior stalls and fires,
    // so exactly one pulse is visible after the 5th edge.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 16'h9900);
      checkOutput($sformatf("timeout_k%0d", k),
                  (k == 5) ? 2'b10 : 2'b00,
                  (k >= 5) ? 2'b10 : 2'b00,
                  (k >= 5), (k >= 5),
                  (k >= 5) ? 2'd3 : 2'd0,
                  8'h00);
    end
    applyStimulus(1'b1, 1'b0, 2'b10, 2'b10, 16'h9900);
    checkOutput("timeout_accept", 2'b00, 2'b10, 1'b1, 1'b1, 2'd3, 8'h10);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000);
    checkOutput("timeout_idle", 2'b00, 2'b10, 1'b1, 1'b1, 2'd3, 8'h10);

    // 20 back-to-back transfers on ch0 saturate its 4-bit counter at 15.
    for (int k = 1; k <= 20; k++) begin
      c0 = (k >= 15) ? 4'hF : 4'(k);
      applyStimulus(1'b1, 1'b0, 2'b01, 2'b01, 16'h00AB);
      checkOutput($sformatf("sat_k%0d", k), 2'b00, 2'b10, 1'b1, 1'b1, 2'd3, {4'h1, c0});
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 16'h0000);
    checkOutput("clr_all", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);

    // Payload change while stalled on ch0, then asynchronous reset mid-stall.
    applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 16'h0001);
    checkOutput("data_a", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 16'h0002);
    checkOutput("data_b", 2'b01, 2'b01, 1'b1, 1'b0, 2'd2, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 16'h0002);
    checkOutput("data_c", 2'b00, 2'b01, 1'b1, 1'b0, 2'd2, 8'h00);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    checkOutput("async_reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);
    #2;
    ASYNCRESET = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000);
    checkOutput("drop_after_reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000);
    checkOutput("idle_after_reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
